// File: rtl/ram_dp_clr.sv
// ram_dp_clr: true dual-port lane-enabled RAM (clock/reset, ports a/b: clken, address, data, wren, be -> q) with rdw mode, optional output register and clear sweep (clear -> busy)
module ram_dp_clr #(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8,
  parameter int lane_width_g = 8,
  parameter int rdw_mode_g = 0,
  parameter int out_reg_g = 0,
  parameter logic [lane_width_g-1:0] clear_val_g = '0,
  parameter int clear_on_reset_g = 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   clken_a,
  input  logic [addr_width_g-1:0]                address_a,
  input  logic [data_width_g-1:0]                data_a,
  input  logic                                   wren_a,
  input  logic [data_width_g/lane_width_g-1:0]   be_a,
  output logic [data_width_g-1:0]                q_a,
  input  logic                                   clken_b,
  input  logic [addr_width_g-1:0]                address_b,
  input  logic [data_width_g-1:0]                data_b,
  input  logic                                   wren_b,
  input  logic [data_width_g/lane_width_g-1:0]   be_b,
  output logic [data_width_g-1:0]                q_b,
  input  logic                                   clear,
  output logic                                   busy
);
  localparam int depth_c = 2 ** addr_width_g;
  localparam int lanes_c = data_width_g / lane_width_g;
  localparam logic [0:0] idle_s = 1'b0;
  localparam logic [0:0] clear_s = 1'b1;
  localparam logic [addr_width_g:0] last_c = (addr_width_g + 1)'(depth_c - 1);
  localparam logic [data_width_g-1:0] clear_word_c = {lanes_c{clear_val_g}};
  logic [data_width_g-1:0] mem [depth_c];
  logic [0:0] state_q, state_d;
  logic [addr_width_g:0] addr_cnt_q, addr_cnt_d;
  logic [lanes_c-1:0] we_a, we_b;
  logic [data_width_g-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, q_a_q, q_a_d, q_b_q, q_b_d;
  function automatic logic [data_width_g-1:0] merge(input logic [data_width_g-1:0] old,
                                                    input logic [data_width_g-1:0] nw,
                                                    input logic [lanes_c-1:0] we);
    logic [data_width_g-1:0] r;
    r = old;
    for (int i = 0; i < lanes_c; i++)
      if (we[i]) r[i*lane_width_g +: lane_width_g] = nw[i*lane_width_g +: lane_width_g];
    return r;
  endfunction
  always_comb begin
    state_d = state_q == idle_s ? (clear ? clear_s : idle_s) : (addr_cnt_q == last_c ? idle_s : clear_s);
    addr_cnt_d = (state_q == clear_s && addr_cnt_q != last_c) ? addr_cnt_q + 1'b1 : '0;
    we_a = (!reset && state_q == idle_s && clken_a && wren_a) ? be_a : '0;
    we_b = (!reset && state_q == idle_s && clken_b && wren_b) ? be_b : '0;
    rd_a_d = clken_a ? (rdw_mode_g != 0 ? merge(mem[address_a], data_a, we_a) : mem[address_a]) : rd_a_q;
    rd_b_d = clken_b ? (rdw_mode_g != 0 ? merge(mem[address_b], data_b, we_b) : mem[address_b]) : rd_b_q;
    q_a_d = clken_a ? rd_a_q : q_a_q;
    q_b_d = clken_b ? rd_b_q : q_b_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= clear_on_reset_g != 0 ? clear_s : idle_s;
      addr_cnt_q <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      state_q <= state_d;
      addr_cnt_q <= addr_cnt_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && state_q == clear_s) mem[addr_cnt_q[addr_width_g-1:0]] <= clear_word_c;
    for (int i = 0; i < lanes_c; i++) begin
      if (we_b[i]) mem[address_b][i*lane_width_g +: lane_width_g] <= data_b[i*lane_width_g +: lane_width_g];
      if (we_a[i]) mem[address_a][i*lane_width_g +: lane_width_g] <= data_a[i*lane_width_g +: lane_width_g];
    end
  end
  assign busy = state_q == clear_s;
  assign q_a = out_reg_g != 0 ? q_a_q : rd_a_q;
  assign q_b = out_reg_g != 0 ? q_b_q : rd_b_q;
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: scoreboard bench driving two ram_dp_clr configurations with shared stimulus
module tb_ram_dp_clr;
  localparam int depth = 2048;
  typedef struct packed {
    logic busy;
    logic [3:0][15:0] q;
  } exp_t;
  logic clk = 0, reset = 0, clear = 0;
  logic clken_a = 0, clken_b = 0, wren_a = 0, wren_b = 0;
  logic [10:0] address_a = 0, address_b = 0;
  logic [15:0] data_a = 0, data_b = 0;
  logic [1:0] be_a = 0, be_b = 0;
  logic [15:0] q_a0, q_b0, q_a1, q_b1;
  logic busy0, busy1;
  int checks = 0, passed = 0;
  logic [15:0] mm [2][depth];
  logic [15:0] last1 [2][2];
  logic [15:0] last2 [2][2];
  int clr_left = depth;
  exp_t sb [$];
  always #5 clk = ~clk;
  ram_dp_clr #(.data_width_g(16)) u0 (
    .clock(clk), .reset(reset),
    .clken_a(clken_a), .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .be_a(be_a), .q_a(q_a0),
    .clken_b(clken_b), .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .be_b(be_b), .q_b(q_b0),
    .clear(clear), .busy(busy0));
  ram_dp_clr #(.data_width_g(16), .rdw_mode_g(1), .out_reg_g(1), .clear_val_g(8'hFF)) u1 (
    .clock(clk), .reset(reset),
    .clken_a(clken_a), .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .be_a(be_a), .q_a(q_a1),
    .clken_b(clken_b), .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .be_b(be_b), .q_b(q_b1),
    .clear(clear), .busy(busy1));
  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction
  task automatic model_step();
    exp_t e;
    logic [15:0] rd;
    logic [10:0] ad [2];
    logic [15:0] dd [2];
    logic [1:0] bb [2];
    logic ck [2];
    logic wr [2];
    ad[0] = address_a; ad[1] = address_b;
    dd[0] = data_a; dd[1] = data_b;
    bb[0] = be_a; bb[1] = be_b;
    ck[0] = clken_a; ck[1] = clken_b;
    wr[0] = wren_a; wr[1] = wren_b;
    if (reset) begin
      clr_left = depth;
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          last1[i][p] = 0;
          last2[i][p] = 0;
        end
    end else begin
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++)
          if (ck[p]) begin
            rd = mm[i][ad[p]];
            if (i == 1 && clr_left == 0 && wr[p])
              for (int l = 0; l < 2; l++)
                if (bb[p][l]) rd[l*8 +: 8] = dd[p][l*8 +: 8];
            last2[i][p] = last1[i][p];
            last1[i][p] = rd;
          end
      if (clr_left > 0) begin
        mm[0][depth - clr_left] = 16'h0000;
        mm[1][depth - clr_left] = 16'hFFFF;
        clr_left--;
      end else begin
        if (clear) clr_left = depth;
        for (int p = 1; p >= 0; p--)
          if (ck[p] && wr[p])
            for (int l = 0; l < 2; l++)
              if (bb[p][l])
                for (int i = 0; i < 2; i++) mm[i][ad[p]][l*8 +: 8] = dd[p][l*8 +: 8];
      end
    end
    e.busy = clr_left > 0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) e.q[i*2+p] = i == 0 ? last1[i][p] : last2[i][p];
    sb.push_back(e);
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("busy0", 16'(busy0), 16'(e.busy));
      chk("busy1", 16'(busy1), 16'(e.busy));
      chk("q_a0", q_a0, e.q[0]);
      chk("q_b0", q_b0, e.q[1]);
      chk("q_a1", q_a1, e.q[2]);
      chk("q_b1", q_b1, e.q[3]);
    end
  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask
  task automatic set_a(input logic ck, input logic wr, input logic [10:0] ad, input logic [15:0] d, input logic [1:0] b);
    clken_a = ck; wren_a = wr; address_a = ad; data_a = d; be_a = b;
  endtask
  task automatic set_b(input logic ck, input logic wr, input logic [10:0] ad, input logic [15:0] d, input logic [1:0] b);
    clken_b = ck; wren_b = wr; address_b = ad; data_b = d; be_b = b;
  endtask
  task automatic rand_io();
    set_a($urandom_range(0, 3) != 0, 1'($urandom), ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15)),
          16'($urandom), 2'($urandom));
    set_b($urandom_range(0, 3) != 0, 1'($urandom), ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15)),
          16'($urandom), 2'($urandom));
  endtask
  task automatic count_sweep(input string nm, input logic traffic);
    int n;
    n = 0;
    while (busy0 && n < 5000) begin
      n++;
      if (traffic) rand_io();
      step();
    end
    chk(nm, 16'(n), 16'(depth));
  endtask
  initial begin
    int n;
    #1 reset = 1;
    @(negedge clk);
    #1;
    repeat (3) step();
    reset = 0;
    count_sweep("init_sweep_len", 1'b0);
    set_a(1, 0, 0, 0, 0); set_b(1, 0, 1234, 0, 0); step();
    chk("rd0_a", q_a0, 16'h0000); chk("rd1234_b", q_b0, 16'h0000);
    set_a(1, 0, 2047, 0, 0); set_b(1, 0, 2047, 0, 0); step();
    chk("rd2047_a", q_a0, 16'h0000); chk("rd1234_b_oreg", q_b1, 16'hFFFF);
    set_b(0, 0, 0, 0, 0);
    set_a(1, 1, 5, 16'hAABB, 2'b11); step();
    set_a(1, 1, 5, 16'h11CC, 2'b01); step();
    set_a(1, 0, 5, 0, 0); step();
    chk("lane_merge", q_a0, 16'hAACC);
    set_a(1, 1, 9, 16'h0022, 2'b11); step();
    set_a(1, 1, 9, 16'h0055, 2'b11); set_b(1, 0, 9, 0, 0); step();
    chk("rdw_old_a", q_a0, 16'h0022); chk("rdw_cross_b0", q_b0, 16'h0022);
    set_a(1, 0, 9, 0, 0); step();
    chk("rdw_new_a1", q_a1, 16'h0055); chk("rdw_cross_b1", q_b1, 16'h0022);
    set_a(1, 1, 7, 16'h0012, 2'b11); set_b(1, 1, 7, 16'h0034, 2'b11); step();
    set_a(1, 0, 7, 0, 0); set_b(1, 0, 7, 0, 0); step();
    chk("coll_a", q_a0, 16'h0012); chk("coll_b", q_b0, 16'h0012);
    set_b(0, 0, 0, 0, 0);
    set_a(1, 0, 5, 0, 0); step();
    chk("oreg_lat", q_a1, 16'h0012);
    set_a(0, 0, 0, 0, 0);
    repeat (3) begin
      step();
      chk("oreg_hold", q_a1, 16'h0012);
    end
    set_a(1, 0, 0, 0, 0); step();
    chk("oreg_adv", q_a1, 16'hAACC);
    repeat (1500) begin rand_io(); step(); end
    rand_io(); clear = 1; step(); clear = 0;
    n = 0;
    while (busy0 && n < 5000) begin
      n++;
      rand_io();
      if (n == 100) begin
        clear = 1;
        set_a(1, 1, 3, 16'h0000, 2'b11);
      end
      step();
      clear = 0;
    end
    chk("clear_sweep_len", 16'(n), 16'(depth));
    set_a(1, 0, 3, 0, 0); set_b(0, 0, 0, 0, 0); step(); step();
    chk("clear_beats_write", q_a1, 16'hFFFF);
    repeat (300) begin rand_io(); step(); end
    clear = 1; step(); clear = 0;
    repeat (500) begin rand_io(); step(); end
    reset = 1;
    #1;
    chk("rst_imm_q_a0", q_a0, 16'h0000); chk("rst_imm_q_a1", q_a1, 16'h0000);
    chk("rst_imm_q_b1", q_b1, 16'h0000);
    step(); step();
    reset = 0;
    count_sweep("rst_sweep_len", 1'b1);
    repeat (300) begin rand_io(); step(); end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
